// File: rtl/vm_clkmon.sv
// ============================================================================
// vm_clkmon : gated edge counter and min/max period monitor for a bench clock
// Revision  : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module vm_clkmon #(
    parameter int CNT_W       = 32,
    parameter int GATE_W      = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              meas_clk,
    input  logic              start,
    input  logic              continuous,
    input  logic [GATE_W-1:0] gate_cycles,
    input  logic [CNT_W-1:0]  exp_min,
    input  logic [CNT_W-1:0]  exp_max,
    output logic              busy,
    output logic              result_valid,
    output logic [CNT_W-1:0]  edge_count,
    output logic [GATE_W-1:0] min_period,
    output logic [GATE_W-1:0] max_period,
    output logic              in_range,
    output logic              stuck
);

    localparam int c_sync_n = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_MEASURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_sync_n-1:0] r_sync;
    logic                r_prev;
    logic [GATE_W-1:0]   r_gate_len;
    logic [GATE_W-1:0]   r_tmo;
    logic [GATE_W-1:0]   r_gate_cnt;
    logic [GATE_W-1:0]   r_per_cnt;
    logic [GATE_W-1:0]   r_min_acc;
    logic [GATE_W-1:0]   r_max_acc;
    logic [CNT_W-1:0]    r_edge_acc;

    logic                w_rise;
    logic [GATE_W-1:0]   w_period;

    // meas_clk is plain asynchronous data here; rise marks a synchronized 0->1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[c_sync_n-2:0], meas_clk};
            r_prev <= r_sync[c_sync_n-1];
        end
    end

    assign w_rise   = r_sync[c_sync_n-1] & ~r_prev;
    assign w_period = (r_per_cnt == '1) ? r_per_cnt : r_per_cnt + GATE_W'(1);
    assign busy     = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_gate_len   <= '0;
            r_tmo        <= '0;
            r_gate_cnt   <= '0;
            r_per_cnt    <= '0;
            r_min_acc    <= '0;
            r_max_acc    <= '0;
            r_edge_acc   <= '0;
            result_valid <= 1'b0;
            edge_count   <= '0;
            min_period   <= '0;
            max_period   <= '0;
            in_range     <= 1'b0;
            stuck        <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && (gate_cycles != '0)) begin
                        r_gate_len <= gate_cycles;
                        r_tmo      <= gate_cycles;
                        r_state    <= S_ARM;
                    end
                end
                S_ARM: begin
                    // The aligning edge opens the window but is not counted
                    if (w_rise) begin
                        r_gate_cnt <= r_gate_len;
                        r_edge_acc <= '0;
                        r_per_cnt  <= '0;
                        r_min_acc  <= '1;
                        r_max_acc  <= '0;
                        r_state    <= S_MEASURE;
                    end else if (r_tmo == GATE_W'(1)) begin
                        r_edge_acc <= '0;
                        r_state    <= S_DONE;
                    end else begin
                        r_tmo <= r_tmo - GATE_W'(1);
                    end
                end
                S_MEASURE: begin
                    r_gate_cnt <= r_gate_cnt - GATE_W'(1);
                    if (w_rise) begin
                        if (r_edge_acc != '1) begin
                            r_edge_acc <= r_edge_acc + CNT_W'(1);
                        end
                        if (w_period < r_min_acc) begin
                            r_min_acc <= w_period;
                        end
                        if (w_period > r_max_acc) begin
                            r_max_acc <= w_period;
                        end
                        r_per_cnt <= '0;
                    end else if (r_per_cnt != '1) begin
                        r_per_cnt <= r_per_cnt + GATE_W'(1);
                    end
                    if (r_gate_cnt == GATE_W'(1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    result_valid <= 1'b1;
                    edge_count   <= r_edge_acc;
                    stuck        <= (r_edge_acc == '0);
                    in_range     <= (r_edge_acc >= exp_min) && (r_edge_acc <= exp_max);
                    min_period   <= (r_edge_acc == '0) ? '0 : r_min_acc;
                    max_period   <= (r_edge_acc == '0) ? '0 : r_max_acc;
                    if (continuous && (gate_cycles != '0)) begin
                        r_gate_len <= gate_cycles;
                        r_tmo      <= gate_cycles;
                        r_state    <= S_ARM;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vm_clkmon.sv
// ============================================================================
// tb_vm_clkmon : randomized self-checking bench for vm_clkmon
// Revision     : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vm_clkmon;

    localparam int CNT_W  = 32;
    localparam int GATE_W = 24;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              meas_clk;
    logic              start = 1'b0;
    logic              continuous = 1'b0;
    logic [GATE_W-1:0] gate_cycles = '0;
    logic [CNT_W-1:0]  exp_min = '0;
    logic [CNT_W-1:0]  exp_max = '0;
    logic              busy;
    logic              result_valid;
    logic [CNT_W-1:0]  edge_count;
    logic [GATE_W-1:0] min_period;
    logic [GATE_W-1:0] max_period;
    logic              in_range;
    logic              stuck;

    int n_chk = 0;
    int n_err = 0;

    // Clock-under-test half periods in ns (= full period in clk cycles); a/b alternate
    int per_a = 5;
    int per_b = 5;
    bit meas_en = 1'b1;

    vm_clkmon #(.CNT_W(CNT_W), .GATE_W(GATE_W), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .meas_clk(meas_clk), .start(start),
        .continuous(continuous), .gate_cycles(gate_cycles),
        .exp_min(exp_min), .exp_max(exp_max), .busy(busy),
        .result_valid(result_valid), .edge_count(edge_count),
        .min_period(min_period), .max_period(max_period),
        .in_range(in_range), .stuck(stuck)
    );

    always #1 clk = ~clk;

    // Edges land 0.3 ns off the clk grid so detection spacing is exact
    initial begin
        meas_clk = 1'b0;
        #0.3;
        forever begin
            if (!meas_en) begin
                meas_clk = 1'b0;
                #1;
            end else begin
                meas_clk = 1'b1; #(per_a);
                meas_clk = 1'b0; #(per_a);
                if (meas_en) begin
                    meas_clk = 1'b1; #(per_b);
                    meas_clk = 1'b0; #(per_b);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded, got no finish, required finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_result(input int budget, output bit got, output int lat);
        got = 1'b0;
        lat = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            lat++;
            if (result_valid) begin
                got = 1'b1;
                return;
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic set_period(input int a, input int b);
        per_a = a;
        per_b = b;
        repeat (40) step();
    endtask

    // Reference: rises after the aligning one sit at k*P cycles; window covers (0, gate]
    task automatic check_uniform(input string tag, input int p, input int gate, input int emin, input int emax);
        int cnt;
        cnt = gate / p;
        chk({tag, "_count"}, edge_count, cnt);
        chk({tag, "_min"}, min_period, (cnt == 0) ? 0 : p);
        chk({tag, "_max"}, max_period, (cnt == 0) ? 0 : p);
        chk({tag, "_stuck"}, stuck, (cnt == 0));
        chk({tag, "_in_range"}, in_range, (cnt >= emin) && (cnt <= emax));
    endtask

    initial begin
        bit got;
        int lat;
        int nres;
        int cap;
        bit saw_busy;

        repeat (4) step();
        chk("rst_busy", busy, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_count", edge_count, 0);
        chk("rst_stuck", stuck, 0);
        rst_n = 1'b1;
        repeat (5) step();

        // Single window, 10 ns clock
        gate_cycles = 1000; exp_min = 190; exp_max = 210;
        pulse_start();
        wait_result(1200, got, lat);
        chk("single_got", got, 1);
        check_uniform("single", 5, 1000, 190, 210);
        step();
        chk("single_pulse", result_valid, 0);
        chk("single_idle", busy, 0);

        // Continuous windows with a frequency change
        continuous = 1'b1;
        pulse_start();
        for (int w = 0; w < 2; w++) begin
            wait_result(1200, got, lat);
            chk("cont_got", got, 1);
            check_uniform("cont200", 5, 1000, 190, 210);
        end
        per_a = 10; per_b = 10;
        wait_result(1200, got, lat);
        chk("cont_trans_got", got, 1);
        wait_result(1200, got, lat);
        chk("cont_new_got", got, 1);
        check_uniform("cont100", 10, 1000, 190, 210);
        continuous = 1'b0;
        wait_result(1200, got, lat);
        chk("cont_last_got", got, 1);
        check_uniform("cont_last", 10, 1000, 190, 210);
        repeat (3) step();
        chk("cont_idle", busy, 0);

        // Stuck clock
        meas_en = 1'b0;
        repeat (20) step();
        gate_cycles = 50; exp_min = 0; exp_max = 5;
        pulse_start();
        wait_result(200, got, lat);
        chk("stuck_got", got, 1);
        chk("stuck_latency", (lat >= 48) && (lat <= 56), 1);
        check_uniform("stuck", 1, 0, 0, 5);

        // Zero gate is ignored
        meas_en = 1'b1;
        set_period(5, 5);
        gate_cycles = 0;
        pulse_start();
        saw_busy = 1'b0; nres = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (busy) saw_busy = 1'b1;
            if (result_valid) nres++;
        end
        chk("zero_gate_busy", saw_busy, 0);
        chk("zero_gate_results", nres, 0);

        // Start while busy is ignored; latched gate unaffected
        gate_cycles = 300; exp_min = 60; exp_max = 60;
        pulse_start();
        nres = 0; cap = 0;
        for (int i = 0; i < 500; i++) begin
            if (i == 50) begin
                gate_cycles = 100;
                start = 1'b1;
            end
            step();
            start = 1'b0;
            if (result_valid) begin
                nres++;
                cap = edge_count;
            end
        end
        chk("busy_start_results", nres, 1);
        chk("busy_start_count", cap, 60);
        chk("busy_start_in_range", in_range, 1);

        // Async reset in the middle of a window
        gate_cycles = 1000; exp_min = 190; exp_max = 210;
        pulse_start();
        repeat (300) step();
        #0.3 rst_n = 1'b0;
        #0.1;
        chk("midrst_busy", busy, 0);
        chk("midrst_count", edge_count, 0);
        chk("midrst_in_range", in_range, 0);
        step();
        rst_n = 1'b1;
        repeat (3) step();
        pulse_start();
        wait_result(1200, got, lat);
        chk("postrst_got", got, 1);
        check_uniform("postrst", 5, 1000, 190, 210);

        // Alternating 10/14 ns periods: 1200 cycles hold exactly 100 of each pair
        set_period(5, 7);
        gate_cycles = 1200; exp_min = 200; exp_max = 200;
        pulse_start();
        wait_result(1400, got, lat);
        chk("alt_got", got, 1);
        chk("alt_count", edge_count, 200);
        chk("alt_min", min_period, 5);
        chk("alt_max", max_period, 7);
        chk("alt_in_range", in_range, 1);

        // Randomized single windows
        for (int it = 0; it < 12; it++) begin
            int p, gate, cnt, emin, emax;
            p    = $urandom_range(3, 12);
            gate = $urandom_range(1, 400);
            cnt  = gate / p;
            emin = cnt + $urandom_range(0, 4) - 2;
            if (emin < 0) emin = 0;
            emax = emin + $urandom_range(0, 3);
            set_period(p, p);
            gate_cycles = gate; exp_min = emin; exp_max = emax;
            pulse_start();
            wait_result(gate + 3 * p + 20, got, lat);
            chk("rand_got", got, 1);
            check_uniform("rand", p, gate, emin, emax);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
